// File: rtl/id_hazard_fwd_pkg.sv
// Shared constants for the decode-stage operand resolution and interlock unit.
// Holds the default widths, the latency encodings, and the scoreboard counter width.
package id_hazard_fwd_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int AREG_W_DEF  = 5;
  localparam int NFWD_DEF    = 2;
  localparam int MAX_LAT_DEF = 3;

  // Default scoreboard counter width, wide enough to hold MAX_LAT_DEF.
  localparam int SB_CW = $clog2(MAX_LAT_DEF + 1);

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD    = '0;
  localparam logic [AREG_W_DEF-1:0] NOP_REG_ADDR = '0;

  typedef enum logic [SB_CW-1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2
  } lat_e;

endpackage

// File: rtl/fwd_sel.sv
// Stateless priority mux for one read port: immediate, hard-wired zero register,
// youngest matching forwarding source, else the register-file data.
module fwd_sel
  import id_hazard_fwd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AREG_W = AREG_W_DEF,
  parameter int NFWD   = NFWD_DEF
) (
  input  logic                     rd_en_i,
  input  logic [AREG_W-1:0]        rd_addr_i,
  input  logic [DATA_W-1:0]        rf_rdata_i,
  input  logic [DATA_W-1:0]        imm_i,
  input  logic [NFWD-1:0]          fwd_valid_i,
  input  logic [NFWD*AREG_W-1:0]   fwd_addr_i,
  input  logic [NFWD*DATA_W-1:0]   fwd_data_i,
  output logic [DATA_W-1:0]        op_o
);

  logic [NFWD-1:0]   hit;
  logic [DATA_W-1:0] src_data [NFWD];
  logic [DATA_W-1:0] fwd_val;

  for (genvar gi = 0; gi < NFWD; gi++) begin : g_src
    assign hit[gi]      = fwd_valid_i[gi] && (fwd_addr_i[gi*AREG_W +: AREG_W] == rd_addr_i);
    assign src_data[gi] = fwd_data_i[gi*DATA_W +: DATA_W];
  end

  // Walk oldest to youngest so the lowest matching index ends up winning.
  always_comb begin
    fwd_val = rf_rdata_i;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (hit[k]) begin
        fwd_val = src_data[k];
      end
    end
  end

  always_comb begin
    op_o = fwd_val;
    if (!rd_en_i) begin
      op_o = imm_i;
    end else if (rd_addr_i == '0) begin
      op_o = '0;
    end
  end

endmodule

// File: rtl/id_hazard_fwd.sv
// Decode-stage operand resolution and interlock: forwards both operands and keeps a
// per-register countdown of cycles until a multi-cycle producer's result is forwardable.
module id_hazard_fwd
  import id_hazard_fwd_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int AREG_W  = AREG_W_DEF,
  parameter  int NFWD    = NFWD_DEF,
  parameter  int MAX_LAT = MAX_LAT_DEF,
  localparam int CW      = $clog2(MAX_LAT + 1),
  localparam int NREGS   = 2 ** AREG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold_i,
  input  logic                     flush_i,
  input  logic                     issue_i,
  input  logic                     issue_wreg_i,
  input  logic [AREG_W-1:0]        issue_wd_i,
  input  logic [CW-1:0]            issue_lat_i,
  input  logic                     rd1_en_i,
  input  logic [AREG_W-1:0]        rd1_addr_i,
  input  logic [DATA_W-1:0]        rf_rdata1_i,
  input  logic [DATA_W-1:0]        imm1_i,
  input  logic                     rd2_en_i,
  input  logic [AREG_W-1:0]        rd2_addr_i,
  input  logic [DATA_W-1:0]        rf_rdata2_i,
  input  logic [DATA_W-1:0]        imm2_i,
  input  logic [NFWD-1:0]          fwd_valid_i,
  input  logic [NFWD*AREG_W-1:0]   fwd_addr_i,
  input  logic [NFWD*DATA_W-1:0]   fwd_data_i,
  output logic [DATA_W-1:0]        op1_o,
  output logic [DATA_W-1:0]        op2_o,
  output logic                     stallreq_o,
  output logic [NREGS-1:0]         busy_o
);

  logic [CW-1:0]     cnt_q [NREGS];
  logic [CW-1:0]     cnt_d [NREGS];
  logic [CW-1:0]     lat_sat;
  logic [31:0]       lat_ext;
  logic              issue_hit;
  logic [NREGS-1:0]  busy_raw;
  logic              rd1_stall;
  logic              rd2_stall;
  logic [DATA_W-1:0] op1_sel;
  logic [DATA_W-1:0] op2_sel;

  fwd_sel #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NFWD(NFWD)) u_sel1 (
    .rd_en_i     (rd1_en_i),
    .rd_addr_i   (rd1_addr_i),
    .rf_rdata_i  (rf_rdata1_i),
    .imm_i       (imm1_i),
    .fwd_valid_i (fwd_valid_i),
    .fwd_addr_i  (fwd_addr_i),
    .fwd_data_i  (fwd_data_i),
    .op_o        (op1_sel)
  );

  fwd_sel #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NFWD(NFWD)) u_sel2 (
    .rd_en_i     (rd2_en_i),
    .rd_addr_i   (rd2_addr_i),
    .rf_rdata_i  (rf_rdata2_i),
    .imm_i       (imm2_i),
    .fwd_valid_i (fwd_valid_i),
    .fwd_addr_i  (fwd_addr_i),
    .fwd_data_i  (fwd_data_i),
    .op_o        (op2_sel)
  );

  // Compared at 32 bits so encodings above MAX_LAT clamp even when CW has spare codes.
  assign lat_ext   = 32'(issue_lat_i);
  assign lat_sat   = (lat_ext > 32'(MAX_LAT)) ? CW'(MAX_LAT) : issue_lat_i;
  assign issue_hit = issue_i && issue_wreg_i && (issue_wd_i != '0);

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush_i) begin
        cnt_d[r] = '0;
      end else if (!hold_i) begin
        cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
        // WAW: keep whichever wait is longer.
        if (issue_hit && (issue_wd_i == AREG_W'(r)) && (lat_sat > cnt_d[r])) begin
          cnt_d[r] = lat_sat;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    assign busy_raw[gi] = |cnt_q[gi];
  end

  assign rd1_stall = rd1_en_i && (rd1_addr_i != '0) && (cnt_q[rd1_addr_i] != '0);
  assign rd2_stall = rd2_en_i && (rd2_addr_i != '0) && (cnt_q[rd2_addr_i] != '0);

  assign stallreq_o = rst ? 1'b0 : (rd1_stall || rd2_stall);
  assign busy_o     = rst ? '0 : busy_raw;
  assign op1_o      = rst ? '0 : op1_sel;
  assign op2_o      = rst ? '0 : op2_sel;

endmodule
